part_demux_latch8: RTL

PART_DEMUX_LATCH8 -- requirements
Module: part_demux_latch8

---
 rtl/part_demux_latch8_pkg.sv | 11 +
 rtl/part_demux_dec3to8.sv | 17 +
 rtl/part_demux_latch8.sv | 99 +++++++++
 3 files changed

// File: rtl/part_demux_latch8_pkg.sv
// Shared definitions for the eight-bit addressable latch: state encoding and data width.
package part_demux_latch8_pkg;

    localparam int WIDTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

endpackage

// File: rtl/part_demux_dec3to8.sv
// Combinational 3-to-8 one-hot decoder; all outputs low when en is low.
module part_demux_dec3to8
    import part_demux_latch8_pkg::*;
(
    input  logic [2:0]       addr,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = WIDTH'(1) << addr;
        end
    end

endmodule

// File: rtl/part_demux_latch8.sv
// Eight-bit addressable latch with direct per-bit writes and a sequenced serial capture mode.
// Handshake: a serial bit is consumed on any rising edge where busy=1 and in_valid=1; there is no backpressure.
module part_demux_latch8
    import part_demux_latch8_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic [2:0]       sel,
    input  logic             we,
    input  logic             clr,
    input  logic             start,
    input  logic             in_valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             busy,
    output logic             done,
    output logic [2:0]       ptr
);

    localparam logic [2:0] FIRST_PTR = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
    localparam logic [2:0] LAST_PTR  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] q_r;
    logic [2:0]       ptr_r;
    logic             done_r;
    logic             last_bit;
    logic             cap_store;
    logic             dir_write;
    logic             cap_start;
    logic [2:0]       dec_addr;
    logic [WIDTH-1:0] load_en;

    assign last_bit = (ptr_r == LAST_PTR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; clr always returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CAPTURE;
            CAPTURE: if (in_valid && last_bit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clr) begin
            state_nx = IDLE;
        end
    end

    // Output/control logic; start beats a same-cycle direct write
    always_comb begin
        busy      = (state == CAPTURE);
        cap_start = (state == IDLE) && start && !clr;
        cap_store = (state == CAPTURE) && in_valid && !clr;
        dir_write = (state == IDLE) && we && !start && !clr;
        dec_addr  = (state == CAPTURE) ? ptr_r : sel;
    end

    part_demux_dec3to8 u_dec (
        .addr   (dec_addr),
        .en     (cap_store | dir_write),
        .onehot (load_en)
    );

    // Data, pointer and done pulse registers
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q_r    <= '0;
            ptr_r  <= 3'd0;
            done_r <= 1'b0;
        end else begin
            q_r    <= (q_r & ~load_en) | (load_en & {WIDTH{d}});
            done_r <= cap_store && last_bit;
            if (cap_start) begin
                ptr_r <= FIRST_PTR;
            end else if (cap_store && !last_bit) begin
                ptr_r <= (LSB_FIRST != 0) ? ptr_r + 3'd1 : ptr_r - 3'd1;
            end
        end
    end

    assign q    = q_r;
    assign q_n  = ~q_r;
    assign done = done_r;
    assign ptr  = ptr_r;

endmodule
